mem_req_arbiter: RTL

//  Two-requester arbiter for the core-side memory request port (addr/wdata/we/cs -> rdata/rvalid).

---
 rtl/mem_req_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: two-requester round-robin arbiter for the core-side memory port.
// Keeps one downstream transaction outstanding at a time and returns the completion to its owner.
// Optional watchdog enabled with `define MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // requester 0
    input  logic                  m0_cs_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_rvalid_o,
    // requester 1
    input  logic                  m1_cs_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_rvalid_o,
    // downstream
    output logic                  dn_cs_o,
    output logic                  dn_we_o,
    output logic [ADDR_WIDTH-1:0] dn_addr_o,
    output logic [DATA_WIDTH-1:0] dn_wdata_o,
    input  logic [DATA_WIDTH-1:0] dn_rdata_i,
    input  logic                  dn_rvalid_i,
    // status
    output logic [1:0]            grant_o,
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_dn_cs;
    logic                  r_dn_we;
    logic [ADDR_WIDTH-1:0] r_dn_addr;
    logic [DATA_WIDTH-1:0] r_dn_wdata;
    logic [1:0]            r_grant;
    logic                  r_busy;
    logic                  r_owner;       // 0 = m0, 1 = m1
    logic                  r_last_grant;  // 0 = m0, 1 = m1

    logic                  w_req_any;
    logic                  w_win_m1;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_complete;

    // Arbitration: a lone requester wins; on a tie the one not served last wins
    assign w_req_any  = m0_cs_i | m1_cs_i;
    assign w_win_m1   = m1_cs_i & (~m0_cs_i | ~r_last_grant);
    assign w_done     = (r_state == S_BUSY) & dn_rvalid_i;
    assign w_complete = w_done | w_timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;

    // Watchdog counter: held at zero outside BUSY, counts BUSY cycles without completion
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_to_cnt <= 16'd0;
        end else if (r_state != S_BUSY) begin
            r_to_cnt <= 16'd0;
        end else if (!dn_rvalid_i) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    // A real completion in the expiry cycle takes precedence over the timeout
    assign w_timeout = (r_state == S_BUSY) & ~dn_rvalid_i & (r_to_cnt == TO_LAST);
`else
    logic w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES >= 32'd2);
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_req_any) w_next_state = S_BUSY;
            S_BUSY:    if (w_complete) w_next_state = S_RELEASE;
            S_RELEASE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Completion routing: zero-latency pulse to the owner only, data zeroed otherwise
    always_comb begin
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        err_o       = w_timeout;
        if (w_complete) begin
            if (r_owner) begin
                m1_rvalid_o = 1'b1;
                m1_rdata_o  = w_done ? dn_rdata_i : '0;
            end else begin
                m0_rvalid_o = 1'b1;
                m0_rdata_o  = w_done ? dn_rdata_i : '0;
            end
        end
    end

    // Downstream request, grant and status registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_dn_cs      <= 1'b0;
            r_dn_we      <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_wdata   <= '0;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_dn_cs    <= 1'b1;
                        r_dn_we    <= w_win_m1 ? m1_we_i    : m0_we_i;
                        r_dn_addr  <= w_win_m1 ? m1_addr_i  : m0_addr_i;
                        r_dn_wdata <= w_win_m1 ? m1_wdata_i : m0_wdata_i;
                        r_grant    <= w_win_m1 ? 2'b10 : 2'b01;
                        r_owner    <= w_win_m1;
                        r_busy     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_complete) begin
                        r_dn_cs      <= 1'b0;
                        r_grant      <= 2'b00;
                        r_last_grant <= r_owner;
                    end
                end
                S_RELEASE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_dn_cs <= 1'b0;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dn_cs_o    = r_dn_cs;
    assign dn_we_o    = r_dn_we;
    assign dn_addr_o  = r_dn_addr;
    assign dn_wdata_o = r_dn_wdata;
    assign grant_o    = r_grant;
    assign busy_o     = r_busy;

endmodule
